// File: rtl/accum_seq_ctrl_pkg.sv
// Shared types and constants for the neuron accumulator sequencer.
// Mode codes match the accumulator's mode input encoding.
package accum_seq_ctrl_pkg;

  localparam int NUM_RES = 11;
  localparam int RES_W   = 16;
  localparam int IDX_W   = 4;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_CLEAR  = 2'b00;
  localparam mode_t MODE_IDLE   = 2'b01;
  localparam mode_t MODE_ACC    = 2'b10;
  localparam mode_t MODE_FINISH = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_RDY,
    S_UNLOAD
  } state_e;

endpackage

// File: rtl/accum_seq_ctrl_delay.sv
// Mode-code delay line matching the operand-memory read latency.
// Reset fills every stage with the idle code.
module mode_delay_line
  import accum_seq_ctrl_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  mode_t d_i,
  output mode_t q_o
);

  mode_t sr_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++)
        sr_q[i] <= MODE_IDLE;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < RD_LAT; i++)
        sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[RD_LAT-1];

endmodule

// File: rtl/accum_seq_ctrl.sv
// Neuron accumulator sequencer: issues tile reads with aligned mode
// codes, captures the result words and streams them downstream.
module accum_seq_ctrl
  import accum_seq_ctrl_pkg::*;
#(
  parameter int NUM_TILES = 8,
  parameter int RD_LAT    = 1,
  parameter int ADDR_W    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [ADDR_W-1:0]        tile_addr_o,
  output logic                     addr_en_o,
  output logic [1:0]               mode_o,
  input  logic                     acc_ready_i,
  input  logic [NUM_RES*RES_W-1:0] res_bus_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [RES_W-1:0]         out_data_o,
  output logic [IDX_W-1:0]         out_idx_o,
  output logic                     out_last_o
);

  localparam logic [ADDR_W-1:0] LAST_TILE = ADDR_W'(NUM_TILES);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_RES-1);

  state_e             state_q;
  logic               busy_q;
  logic               done_q;
  logic               addr_en_q;
  logic [ADDR_W-1:0]  tile_addr_q;
  logic [RES_W-1:0]   words_q [NUM_RES];
  logic               out_valid_q;
  logic [RES_W-1:0]   out_data_q;
  logic [IDX_W-1:0]   out_idx_q;
  logic               out_last_q;
  logic [IDX_W-1:0]   idx_nxt;
  mode_t              tag_d;

  // Tag follows the address currently presented to the operand memory.
  always_comb begin
    tag_d = MODE_IDLE;
    unique case (1'b1)
      !addr_en_q:
        tag_d = MODE_IDLE;
      addr_en_q && (tile_addr_q == '0):
        tag_d = MODE_CLEAR;
      addr_en_q && (tile_addr_q == LAST_TILE):
        tag_d = MODE_FINISH;
      default:
        tag_d = MODE_ACC;
    endcase
  end

  assign idx_nxt = out_idx_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr_en_q   <= 1'b0;
      tile_addr_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < NUM_RES; i++)
        words_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q     <= S_FETCH;
            busy_q      <= 1'b1;
            addr_en_q   <= 1'b1;
            tile_addr_q <= '0;
          end
        end
        S_FETCH: begin
          if (tile_addr_q == LAST_TILE) begin
            state_q   <= S_WAIT_RDY;
            addr_en_q <= 1'b0;
          end else begin
            tile_addr_q <= tile_addr_q + 1'b1;
          end
        end
        S_WAIT_RDY: begin
          if (acc_ready_i) begin
            for (int i = 0; i < NUM_RES; i++)
              words_q[i] <= res_bus_i[i*RES_W +: RES_W];
            state_q     <= S_UNLOAD;
            out_valid_q <= 1'b1;
            out_data_q  <= res_bus_i[RES_W-1:0];
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
          end
        end
        S_UNLOAD: begin
          if (out_ready_i) begin
            if (out_last_q) begin
              state_q     <= S_IDLE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              out_idx_q   <= '0;
              out_last_q  <= 1'b0;
            end else begin
              out_idx_q  <= idx_nxt;
              out_data_q <= words_q[idx_nxt];
              out_last_q <= (idx_nxt == LAST_IDX);
            end
          end
        end
      endcase
    end
  end

  mode_delay_line #(
    .RD_LAT (RD_LAT)
  ) u_mode_dl (
    .clk (clk),
    .rst (rst),
    .d_i (tag_d),
    .q_o (mode_o)
  );

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign addr_en_o   = addr_en_q;
  assign tile_addr_o = tile_addr_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_idx_o   = out_idx_q;
  assign out_last_o  = out_last_q;

endmodule

// File: doc/accum_seq_ctrl.md
# accum_seq_ctrl

Initiator and result reader for the neuron accumulator. Per neuron it sequences one pass of input tiles through the product array: it drives tile read addresses and the accumulator `mode` code, aligned to the operand-memory read latency. It then waits for the accumulator's `ready`, captures the eleven 16-bit results, and streams them out one word at a time over a valid/ready handshake to the activation/writeback stage.

## Interface
- `NUM_TILES`, 8: layer-1 tiles per neuron (98 products each); legal range ≥1.
- `RD_LAT`, 1: operand-memory read latency in cycles, from `tile_addr` to products at the accumulator inputs; legal range 1..4.
- `ADDR_W`, 4: `tile_addr` width; must hold the value `NUM_TILES`.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin one neuron pass; sampled only in IDLE.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse after the last result word is accepted.
- `tile_addr` out ADDR_W: operand-memory read address.
- `addr_en` out 1: `tile_addr` is valid this cycle.
- `mode` out 2: accumulator mode code.
- `acc_ready` in 1: accumulator ready flag.
- `res_bus` in 176: accumulator results; word i (0..10) occupies bits 16i+15:16i, in sign + Q15.8-slice format.
- `out_valid` out 1: result word available.
- `out_ready` in 1: downstream accepts the word.
- `out_data` out 16: result word.
- `out_idx` out 4: word index, 0..10.
- `out_last` out 1: high with index 10.

## Operation
- Mode codes:
  - 00 CLEAR: load acc0, clear acc1..10, ready←0.
  - 01 IDLE: load acc0, hold acc1..10, ready←0.
  - 10 ACC: acc0 += sum, hold the rest.
  - 11 FINISH: all accumulate, ready←1.
- States: IDLE → FETCH → WAIT_RDY → UNLOAD → IDLE.
- IDLE:
  - `start`=1 → FETCH, `busy`←1, internal tile counter←0.
  - Otherwise stay.
  - Issued mode is 01.
- FETCH:
  - Each cycle issues `tile_addr`=counter with `addr_en`=1, then counter+1.
  - Tile 0 is tagged 00, tiles 1..NUM_TILES-1 are tagged 10, and tile NUM_TILES (the layer-2 product slot) is tagged 11.
  - After issuing tile NUM_TILES → WAIT_RDY.
- Mode alignment: the tag passes through an RD_LAT-deep delay line to `mode`. A non-issuing cycle inserts 01.
- WAIT_RDY: on `acc_ready`=1, capture all 11 words of `res_bus` into local registers → UNLOAD. `acc_ready` is ignored in any other state.
- UNLOAD:
  - Present word `out_idx`, beginning at 0.
  - On `out_valid`&&`out_ready`: at index 10 → IDLE with `done`=1 and `busy`=0 in the next cycle; otherwise index+1.
  - `out_data`, `out_idx` and `out_last` stay stable while `out_valid`&&!`out_ready`.
- `start` is ignored while `busy`=1.
- Mid-operation `rst`: return to IDLE, flush the delay line to 01, drop `out_valid`, discard captured words.

## Timing
- Reset values: `busy` 0, `done` 0, `tile_addr` 0, `addr_en` 0, `mode` 01, `out_valid` 0, `out_data` 0, `out_idx` 0, `out_last` 0; delay line all 01.
- `start` sampled high at cycle 0 → `addr_en`=1 in cycles 1..NUM_TILES+1, with `tile_addr`=k in cycle k+1.
- `mode` for tile k appears in cycle k+1+RD_LAT.
- `acc_ready` is expected in cycle NUM_TILES+2+RD_LAT. Capture happens at the end of that cycle, and `out_valid`=1 from the next cycle.
- With continuous `out_ready`, the 11 words occupy 11 consecutive cycles, and `done` follows the last word by 1 cycle.
- All outputs are registered. There is no combinational path from `out_ready` or `acc_ready` to any output.

## Structure
- Shared package:
  - mode constants MODE_CLEAR, MODE_IDLE, MODE_ACC, MODE_FINISH;
  - NUM_RES=11, RES_W=16;
  - the state enum.
- Sub-module `mode_delay_line`: parameterised RD_LAT shift register of 2-bit codes, reset-filled with MODE_IDLE.
- The serializer stays inline.

## Test plan
- NUM_TILES=8, RD_LAT=1, `out_ready`=1, accumulator model attached:
  - `mode` is 01, then 00 in cycle 2, 10 in cycles 3..9, 11 in cycle 10, then 01;
  - `acc_ready` arrives in cycle 11;
  - words 0..10 appear in cycles 12..22, with `out_last` in cycle 22 and `done` in cycle 23.
- `res_bus` word i = 16'h0100+i, `out_ready` toggling 1/0 → the words are accepted in order 0..10 with values 16'h0100..16'h010A, stable during stalls.
- NUM_TILES=1, RD_LAT=3 → `tile_addr` 0 then 1; `mode` 00 in cycle 4, 11 in cycle 5; `acc_ready` in cycle 6.
- `start` pulsed in cycle 4 of a pass, and `acc_ready` forced high during IDLE → no restart, no capture, no `out_valid`.
- `rst` in cycle 5 of FETCH → the next cycle shows reset values; a fresh `start` reproduces the first scenario exactly.
